// File: rtl/opc_intctl.sv
`default_nettype none
// ============================================================================
// Module   : opc_intctl
// Purpose  : Prioritised, nesting, vectored interrupt controller with config regs
// Revision : 1.0
// ============================================================================
module opc_intctl #(
    parameter int                NUM_IRQ    = 8,
    parameter int                DATA_W     = 24,
    parameter int                NEST_DEPTH = 4,
    parameter logic [DATA_W-1:0] VEC_BASE   = 24'h10,
    parameter int                VEC_STRIDE = 2
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               clken,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_sel,
    input  logic               cfg_rnw,
    input  logic [1:0]         cfg_addr,
    input  logic [DATA_W-1:0]  cfg_din,
    output logic [DATA_W-1:0]  cfg_dout,
    output logic               int_b,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic [DATA_W-1:0]  vector
);

    localparam logic [1:0] c_ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] c_ADDR_MODE    = 2'd1;
    localparam logic [1:0] c_ADDR_PENDING = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS  = 2'd3;
    localparam logic [3:0] c_DEPTH_MAX    = 4'(NEST_DEPTH);

    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_sync_prev;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_pending;
    logic [3:0]         r_stack [NEST_DEPTH];
    logic [3:0]         r_depth;
    logic               r_int_b;
    logic [DATA_W-1:0]  r_vector;
    logic [DATA_W-1:0]  r_cfg_dout;

    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_wr_clear;
    logic [NUM_IRQ-1:0] w_ack_clear;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic [3:0]         w_winner;
    logic               w_any;
    logic               w_empty;
    logic               w_full;
    logic [3:0]         w_top;
    logic [3:0]         w_second;
    logic               w_cfg_wr;
    logic               w_cfg_rd;
    logic               w_do_ack;
    logic               w_do_eoi;
    logic               w_req;
    logic               w_int_b_nxt;
    logic [3:0]         w_depth_nxt;
    logic [DATA_W-1:0]  w_vector_nxt;
    logic [8:0]         w_status;
    logic [DATA_W-1:0]  w_rd_data;

    function automatic logic [DATA_W-1:0] vec_of(input logic [3:0] id);
        return VEC_BASE + DATA_W'(id) * DATA_W'(VEC_STRIDE);
    endfunction

    // Stack is kept as a shift register: entry 0 is always the top and
    // entries above the current depth are held at zero.
    generate
        if (NEST_DEPTH > 1) begin : g_second
            assign w_second = r_stack[1];
        end else begin : g_no_second
            assign w_second = 4'd0;
        end
    endgenerate

    generate
        if (DATA_W > NUM_IRQ) begin : g_din_unused
            logic w_unused_din;
            assign w_unused_din = &{1'b0, cfg_din[DATA_W-1:NUM_IRQ]};
        end
    endgenerate

    assign w_empty    = (r_depth == 4'd0);
    assign w_full     = (r_depth == c_DEPTH_MAX);
    assign w_top      = w_empty ? 4'd0 : r_stack[0];
    assign w_eligible = r_pending & r_enable;
    assign w_cfg_wr   = cfg_sel & ~cfg_rnw;
    assign w_cfg_rd   = cfg_sel & cfg_rnw;

    // Lowest eligible index wins.
    always_comb begin
        w_winner = 4'd0;
        w_any    = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 4'(i);
                w_any    = 1'b1;
            end
        end
    end

    assign w_do_eoi = int_eoi & ~w_empty;
    assign w_do_ack = int_ack & ~r_int_b & w_any & (~w_full | w_do_eoi);
    assign w_req    = w_any & ~w_full & (w_empty | (w_winner < w_top));

    // A new edge in the same cycle as a clear keeps the request pending.
    assign w_rise        = r_sync2 & ~r_sync_prev;
    assign w_wr_clear    = (w_cfg_wr && cfg_addr == c_ADDR_PENDING) ? cfg_din[NUM_IRQ-1:0] : '0;
    assign w_ack_clear   = w_do_ack ? (NUM_IRQ'(1) << w_winner) : '0;
    assign w_pending_nxt = (r_mode & ((r_pending & ~(w_wr_clear | w_ack_clear)) | w_rise))
                         | (~r_mode & r_sync2);

    always_comb begin
        w_depth_nxt = r_depth;
        case ({w_do_ack, w_do_eoi})
            2'b10:   w_depth_nxt = r_depth + 4'd1;
            2'b01:   w_depth_nxt = r_depth - 4'd1;
            default: w_depth_nxt = r_depth;
        endcase
    end

    always_comb begin
        w_vector_nxt = r_vector;
        if (w_do_ack) begin
            w_vector_nxt = vec_of(w_winner);
        end else if (w_do_eoi) begin
            w_vector_nxt = (r_depth == 4'd1) ? VEC_BASE : vec_of(w_second);
        end
    end

    assign w_int_b_nxt = w_do_ack ? 1'b1 : ~w_req;

    assign w_status = {r_depth, w_top, w_empty};

    always_comb begin
        w_rd_data = '0;
        case (cfg_addr)
            c_ADDR_ENABLE:  w_rd_data = DATA_W'(r_enable);
            c_ADDR_MODE:    w_rd_data = DATA_W'(r_mode);
            c_ADDR_PENDING: w_rd_data = DATA_W'(r_pending);
            c_ADDR_STATUS:  w_rd_data = DATA_W'(w_status);
            default:        w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clken) begin
            if (!reset_b) begin
                r_sync1     <= '0;
                r_sync2     <= '0;
                r_sync_prev <= '0;
                r_enable    <= '0;
                r_mode      <= '0;
                r_pending   <= '0;
                r_depth     <= 4'd0;
                r_int_b     <= 1'b1;
                r_vector    <= VEC_BASE;
                r_cfg_dout  <= '0;
                for (int i = 0; i < NEST_DEPTH; i++) begin
                    r_stack[i] <= 4'd0;
                end
            end else begin
                r_sync1     <= irq_in;
                r_sync2     <= r_sync1;
                r_sync_prev <= r_sync2;
                r_pending   <= w_pending_nxt;
                if (w_cfg_wr && cfg_addr == c_ADDR_ENABLE) begin
                    r_enable <= cfg_din[NUM_IRQ-1:0];
                end
                if (w_cfg_wr && cfg_addr == c_ADDR_MODE) begin
                    r_mode <= cfg_din[NUM_IRQ-1:0];
                end
                if (w_cfg_rd) begin
                    r_cfg_dout <= w_rd_data;
                end
                r_depth  <= w_depth_nxt;
                r_int_b  <= w_int_b_nxt;
                r_vector <= w_vector_nxt;
                // Simultaneous ack and eoi replaces the top in place.
                if (w_do_ack && w_do_eoi) begin
                    r_stack[0] <= w_winner;
                end else if (w_do_ack) begin
                    r_stack[0] <= w_winner;
                    for (int i = 1; i < NEST_DEPTH; i++) begin
                        r_stack[i] <= r_stack[i-1];
                    end
                end else if (w_do_eoi) begin
                    for (int i = 0; i < NEST_DEPTH - 1; i++) begin
                        r_stack[i] <= r_stack[i+1];
                    end
                    r_stack[NEST_DEPTH-1] <= 4'd0;
                end
            end
        end
    end

    assign cfg_dout = r_cfg_dout;
    assign int_b    = r_int_b;
    assign vector   = r_vector;

endmodule
`default_nettype wire

// File: tb/tb_opc_intctl.sv
`default_nettype none
// Bench for opc_intctl: config table, directed nesting/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_opc_intctl;

    logic        clk = 1'b0;
    logic        reset_b, clken, cfg_sel, cfg_rnw, int_ack, int_eoi;
    logic [7:0]  irq_in;
    logic [1:0]  cfg_addr;
    logic [23:0] cfg_din;
    logic [23:0] cfg_dout, vector, cfg_dout2, vector2;
    logic        int_b, int_b2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    opc_intctl u_dut (
        .clk(clk), .reset_b(reset_b), .clken(clken), .irq_in(irq_in),
        .cfg_sel(cfg_sel), .cfg_rnw(cfg_rnw), .cfg_addr(cfg_addr), .cfg_din(cfg_din),
        .cfg_dout(cfg_dout), .int_b(int_b), .int_ack(int_ack), .int_eoi(int_eoi),
        .vector(vector)
    );

    opc_intctl #(.NEST_DEPTH(2)) u_dut2 (
        .clk(clk), .reset_b(reset_b), .clken(clken), .irq_in(irq_in),
        .cfg_sel(cfg_sel), .cfg_rnw(cfg_rnw), .cfg_addr(cfg_addr), .cfg_din(cfg_din),
        .cfg_dout(cfg_dout2), .int_b(int_b2), .int_ack(int_ack), .int_eoi(int_eoi),
        .vector(vector2)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_b = 1'b0; tick(); reset_b = 1'b1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [23:0] d);
        cfg_sel = 1'b1; cfg_rnw = 1'b0; cfg_addr = a; cfg_din = d;
        tick();
        cfg_sel = 1'b0;
    endtask

    task automatic cfg_rd(input logic [1:0] a, output logic [23:0] d);
        cfg_sel = 1'b1; cfg_rnw = 1'b1; cfg_addr = a;
        tick();
        cfg_sel = 1'b0;
        d = cfg_dout;
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_in = m; tick(); irq_in = 8'h00;
    endtask

    task automatic ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic eoi();
        int_eoi = 1'b1; tick(); int_eoi = 1'b0;
    endtask

    task automatic wait_low(input bit second, input int max_cyc, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            tick();
            if ((second ? int_b2 : int_b) == 1'b0) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // ---------------- reference model ----------------
    bit [7:0]  m_s1, m_s2, m_prev, m_en, m_mode, m_pend;
    int        m_stk[$];
    bit        m_int_b;
    bit [23:0] m_vec, m_dout;

    function automatic bit [23:0] vec_for(input int id);
        return 24'(16 + id * 2);
    endfunction

    task automatic model_step();
        int w, top;
        bit any, full, empty, do_ack, do_eoi, rise, clr;
        bit [7:0] nxt;
        if (!clken) return;
        if (!reset_b) begin
            m_s1 = 0; m_s2 = 0; m_prev = 0; m_en = 0; m_mode = 0; m_pend = 0;
            m_stk.delete(); m_int_b = 1; m_vec = 24'h10; m_dout = 0;
            return;
        end
        any = 0; w = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && m_en[i]) begin w = i; any = 1; break; end
        end
        full   = (m_stk.size() == 4);
        empty  = (m_stk.size() == 0);
        top    = empty ? 0 : m_stk[0];
        do_eoi = int_eoi && !empty;
        do_ack = int_ack && !m_int_b && any && (!full || do_eoi);
        if (cfg_sel && cfg_rnw) begin
            case (cfg_addr)
                2'd0: m_dout = 24'(m_en);
                2'd1: m_dout = 24'(m_mode);
                2'd2: m_dout = 24'(m_pend);
                default: m_dout = 24'(m_stk.size() * 32 + top * 2 + (empty ? 1 : 0));
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i]) begin
                rise = m_s2[i] && !m_prev[i];
                clr  = (cfg_sel && !cfg_rnw && cfg_addr == 2'd2 && cfg_din[i]) || (do_ack && w == i);
                nxt[i] = rise || (m_pend[i] && !clr);
            end else begin
                nxt[i] = m_s2[i];
            end
        end
        m_int_b = do_ack ? 1'b1 : !(any && !full && (empty || w < top));
        if (do_eoi) void'(m_stk.pop_front());
        if (do_ack) m_stk.push_front(w);
        if (do_ack) m_vec = vec_for(w);
        else if (do_eoi) m_vec = (m_stk.size() == 0) ? 24'h10 : vec_for(m_stk[0]);
        if (cfg_sel && !cfg_rnw && cfg_addr == 2'd0) m_en = cfg_din[7:0];
        if (cfg_sel && !cfg_rnw && cfg_addr == 2'd1) m_mode = cfg_din[7:0];
        m_pend = nxt;
        m_prev = m_s2; m_s2 = m_s1; m_s1 = irq_in;
    endtask

    typedef struct {
        logic [1:0]  wr_addr;
        logic [23:0] wr_data;
        logic [1:0]  rd_addr;
        logic [23:0] exp_dout;
    } cfg_vec_t;

    initial begin
        cfg_vec_t    tbl [7];
        logic [23:0] d;
        bit          hold_ok;

        tbl[0] = '{2'd0, 24'hFFFF5A, 2'd0, 24'h00005A};
        tbl[1] = '{2'd1, 24'h0000C3, 2'd1, 24'h0000C3};
        tbl[2] = '{2'd3, 24'hFFFFFF, 2'd3, 24'h000001};
        tbl[3] = '{2'd2, 24'hFFFFFF, 2'd2, 24'h000000};
        tbl[4] = '{2'd0, 24'h000000, 2'd0, 24'h000000};
        tbl[5] = '{2'd1, 24'h0000FF, 2'd0, 24'h000000};
        tbl[6] = '{2'd3, 24'h000011, 2'd1, 24'h0000FF};

        reset_b = 1'b1; clken = 1'b1; irq_in = 8'h00; cfg_sel = 1'b0; cfg_rnw = 1'b0;
        cfg_addr = 2'd0; cfg_din = 24'h0; int_ack = 1'b0; int_eoi = 1'b0;

        do_reset();
        check("reset_int_b", 32'(int_b), 32'd1);
        check("reset_vector", 32'(vector), 32'h10);
        check("reset_cfg_dout", 32'(cfg_dout), 32'h0);

        for (int i = 0; i < 7; i++) begin
            cfg_wr(tbl[i].wr_addr, tbl[i].wr_data);
            cfg_rd(tbl[i].rd_addr, d);
            check($sformatf("cfg_tbl[%0d]", i), 32'(d), 32'(tbl[i].exp_dout));
            check($sformatf("cfg_tbl_int_b[%0d]", i), 32'(int_b), 32'd1);
        end

        // single edge request on ch3
        do_reset();
        cfg_wr(2'd0, 24'h08); cfg_wr(2'd1, 24'h08);
        pulse(8'h08); tick(); tick();
        check("ch3_not_yet", 32'(int_b), 32'd1);
        tick();
        check("ch3_int_b_low", 32'(int_b), 32'd0);
        ack();
        check("ch3_vector", 32'(vector), 32'h16);
        check("ch3_int_b_after_ack", 32'(int_b), 32'd1);
        cfg_rd(2'd2, d); check("ch3_pending_cleared", 32'(d), 32'h0);
        cfg_rd(2'd3, d); check("ch3_status", 32'(d), 32'h26);
        eoi();
        check("ch3_eoi_vector", 32'(vector), 32'h10);
        cfg_rd(2'd3, d); check("ch3_eoi_status", 32'(d), 32'h001);

        // priority ch2 over ch5
        do_reset();
        cfg_wr(2'd0, 24'h24); cfg_wr(2'd1, 24'h24);
        pulse(8'h24); tick(); tick(); tick();
        check("prio_int_b_low", 32'(int_b), 32'd0);
        ack();
        check("prio_vector_ch2", 32'(vector), 32'h14);
        tick();
        check("prio_ch5_blocked", 32'(int_b), 32'd1);
        eoi();
        check("prio_eoi_vector", 32'(vector), 32'h10);
        tick();
        check("prio_ch5_asserts", 32'(int_b), 32'd0);
        ack();
        check("prio_vector_ch5", 32'(vector), 32'h1A);
        eoi();

        // nesting ch6 -> ch1, ch7 blocked
        do_reset();
        cfg_wr(2'd0, 24'hFF); cfg_wr(2'd1, 24'hFF);
        pulse(8'h40); wait_low(0, 8, "nest_ch6_req");
        ack(); check("nest_vector_ch6", 32'(vector), 32'h1C);
        pulse(8'h02); wait_low(0, 8, "nest_ch1_req");
        ack(); check("nest_vector_ch1", 32'(vector), 32'h12);
        cfg_rd(2'd3, d); check("nest_status_depth2", 32'(d), 32'h42);
        pulse(8'h80);
        hold_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (int_b !== 1'b1) hold_ok = 1'b0;
        end
        check("nest_ch7_held_off", 32'(hold_ok), 32'd1);
        eoi(); check("nest_pop_vector_ch6", 32'(vector), 32'h1C);
        eoi(); check("nest_pop_vector_base", 32'(vector), 32'h10);
        wait_low(0, 4, "nest_ch7_after_pops");

        // depth-2 instance: full stack blocks ch0 until eoi
        do_reset();
        cfg_wr(2'd0, 24'hFF); cfg_wr(2'd1, 24'hFF);
        pulse(8'h08); wait_low(1, 8, "full_ch3_req"); ack();
        pulse(8'h02); wait_low(1, 8, "full_ch1_req"); ack();
        check("full_vector_ch1", 32'(vector2), 32'h12);
        pulse(8'h01);
        hold_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (int_b2 !== 1'b1) hold_ok = 1'b0;
        end
        check("full_int_b_held", 32'(hold_ok), 32'd1);
        check("full_deep_inst_nests", 32'(int_b), 32'd0);
        eoi();
        check("full_eoi_vector", 32'(vector2), 32'h16);
        tick();
        check("full_eoi_int_b_low", 32'(int_b2), 32'd0);

        // level mode ignores write-1-clear
        do_reset();
        cfg_wr(2'd0, 24'h10); cfg_wr(2'd1, 24'h00);
        irq_in = 8'h10; tick(); tick(); tick();
        cfg_rd(2'd2, d); check("level_pending_set", 32'(d), 32'h10);
        cfg_wr(2'd2, 24'h10);
        cfg_rd(2'd2, d); check("level_w1c_ignored", 32'(d), 32'h10);
        check("level_int_b_low", 32'(int_b), 32'd0);
        irq_in = 8'h00; tick(); tick(); tick();
        cfg_rd(2'd2, d); check("level_pending_drops", 32'(d), 32'h0);

        // reset mid-operation with depth 3
        do_reset();
        cfg_wr(2'd0, 24'hFF); cfg_wr(2'd1, 24'hFF);
        pulse(8'h20); wait_low(0, 8, "rst_ch5_req"); ack();
        pulse(8'h08); wait_low(0, 8, "rst_ch3_req"); ack();
        pulse(8'h02); wait_low(0, 8, "rst_ch1_req"); ack();
        pulse(8'hC0); tick(); tick(); tick();
        cfg_rd(2'd3, d); check("rst_status_depth3", 32'(d), 32'h62);
        cfg_rd(2'd2, d); check("rst_pending_pre", 32'(d), 32'hC0);
        reset_b = 1'b0; int_ack = 1'b1; int_eoi = 1'b1;
        cfg_sel = 1'b1; cfg_rnw = 1'b0; cfg_addr = 2'd0; cfg_din = 24'hFF;
        tick();
        reset_b = 1'b1; int_ack = 1'b0; int_eoi = 1'b0; cfg_sel = 1'b0;
        check("rst_int_b", 32'(int_b), 32'd1);
        check("rst_vector", 32'(vector), 32'h10);
        check("rst_cfg_dout", 32'(cfg_dout), 32'h0);
        cfg_rd(2'd0, d); check("rst_enable", 32'(d), 32'h0);
        cfg_rd(2'd1, d); check("rst_mode", 32'(d), 32'h0);
        cfg_rd(2'd2, d); check("rst_pending", 32'(d), 32'h0);
        cfg_rd(2'd3, d); check("rst_status", 32'(d), 32'h001);

        // clken=0 freezes everything, including reset and config
        cfg_wr(2'd0, 24'h04); cfg_wr(2'd1, 24'h04);
        pulse(8'h04); tick(); tick(); tick();
        check("clken_pre_int_b", 32'(int_b), 32'd0);
        clken = 1'b0; reset_b = 1'b0; int_ack = 1'b1; int_eoi = 1'b1; irq_in = 8'hFF;
        cfg_sel = 1'b1; cfg_rnw = 1'b1; cfg_addr = 2'd0;
        hold_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (int_b !== 1'b0 || vector !== 24'h10 || cfg_dout !== 24'h001) hold_ok = 1'b0;
        end
        check("clken_hold", 32'(hold_ok), 32'd1);
        clken = 1'b1; reset_b = 1'b1; int_eoi = 1'b0; cfg_sel = 1'b0; irq_in = 8'h00;
        tick();
        int_ack = 1'b0;
        check("clken_resume_vector", 32'(vector), 32'h14);

        // randomized traffic against the model
        int_ack = 1'b0; int_eoi = 1'b0; cfg_sel = 1'b0; irq_in = 8'h00;
        reset_b = 1'b0; clken = 1'b1;
        model_step(); tick();
        for (int c = 0; c < 3000; c++) begin
            clken   = ($urandom_range(0, 15) != 0);
            reset_b = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (8'h01 << $urandom_range(0, 7));
            cfg_sel  = ($urandom_range(0, 3) == 0);
            cfg_rnw  = ($urandom_range(0, 1) == 1);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_din  = 24'($urandom);
            int_ack  = m_int_b ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
            int_eoi  = ($urandom_range(0, 11) == 0);
            model_step();
            tick();
            check("rnd_int_b", 32'(int_b), 32'(m_int_b));
            check("rnd_vector", 32'(vector), 32'(m_vec));
            check("rnd_cfg_dout", 32'(cfg_dout), 32'(m_dout));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
